mips_single_cycle: RTL and testbench
====================================

MIPS_SINGLE_CYCLE -- requirements
Module: mips_single_cycle

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have no other ports; program and data are preloaded by backdoor into internal arrays.
REQ-004 SHALL expose these hierarchical names for bench access:
- pc.current_instruction: 32-bit PC register.
- imem.IM[0:255]: 8-bit instruction memory.
- dmem.dmem[0:255]: 8-bit data memory.
- rf.RF[0:31]: 32-bit register file.
- instruction: 32-bit fetched-word wire.

Function
REQ-005 SHALL be single-cycle: each rising clk edge with rst_n=1 retires exactly one instruction.
REQ-006 SHALL fetch combinationally, big-endian: instruction = {IM[PC],IM[PC+1],IM[PC+2],IM[PC+3]}; byte addresses taken modulo 256.
REQ-007 SHALL read data memory combinationally, big-endian, from 4 bytes at addr..addr+3 (mod 256); stores write the same 4 bytes big-endian at the rising edge.
REQ-008 SHALL read the register file combinationally (rs, rt) and write one register at the rising edge; writes to $0 are discarded and $0 always reads 0.
REQ-009 SHALL decode R-type (opcode 0x00) by funct with rd written:
- 0x20 add: rs+rt.
- 0x22 sub: rs-rt.
- 0x24 and; 0x25 or.
- 0x2A slt: signed rs<rt gives 1, else 0.
- Arithmetic is 32-bit wrap-around; no overflow exception.
REQ-010 SHALL support I-type instructions, with imm sign-extended and effective address rs+imm:
- 0x23 lw: rt <= M[rs+imm].
- 0x2B sw: M[rs+imm] <= rt.
- 0x08 addi: rt <= rs+imm.
- 0x04 beq.
REQ-011 SHALL compute next PC:
- beq taken (rs==rt): PC+4+(sext(imm)<<2).
- j (opcode 0x02): {PC+4[31:28], target26, 2'b00}.
- Otherwise: PC+4.
REQ-012 SHALL treat any unsupported opcode/funct as a no-op: PC+4, no register or memory write.
REQ-013 SHALL perform a load and a register write in the same instruction with memory data forwarded combinationally (lw result visible in rt after that edge).
REQ-014 SHALL allow a store and a following load to the same address in consecutive cycles, with the load returning the stored value.
REQ-015 SHALL NOT modify memory contents on a beq, j or no-op.

Reset
REQ-016 SHALL, at a rising clk edge with rst_n=0, set PC=0 and clear rf.RF[1..31] to 0.
REQ-017 SHALL leave IM and dmem untouched by reset.
REQ-018 SHALL suppress all register and memory writes in a reset cycle.
REQ-019 SHALL, on reset asserted mid-program, abandon the current instruction with no side effects and resume fetch at address 0 on the first edge with rst_n=1.

Verification
REQ-020 Reference program:
- Preload dmem[0..3]=00000005, dmem[4..7]=00000003, dmem[8..15]=0.
- IM @0: 8C010000, 8C020004, 00221820, 00222022, AD030008, AD04000C, 8D05000C, 00451020, 10220010; IM @100: 08000019.
- Reset, then run 9 cycles -> R1=5, R3=8, R4=2, R5=2, R2=5, M[8]=00000008, M[12]=00000002, PC=0x64 (beq taken).
REQ-021 From REQ-020 state, the j at 0x64 -> PC stays 0x64 every cycle thereafter; registers and memory unchanged.
REQ-022 beq not taken: R1=5, R2=3, beq $1,$2,16 at PC 0x20 -> PC=0x24.
REQ-023 Write to $0: add $0,$1,$2 with R1=5, R2=3 -> RF[0] reads 0, PC+4.
REQ-024 Signed ops:
- addi $6,$0,-1 -> R6=FFFFFFFF.
- slt $7,$6,$0 -> R7=1.
- sub $8,$0,$1 with R1=5 -> R8=FFFFFFFB.
REQ-025 Reset mid-run: assert rst_n=0 for one edge while PC=0x10 -> PC=0, R1..R31=0, dmem unchanged; program reruns from address 0.

Source files
------------

// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS subset core: add/sub/and/or/slt, lw/sw/addi/beq, j.
// Byte-wide instruction and data memories, big-endian, 256-byte address space.

module mips_pc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_o
);
  logic [31:0] current_instruction;

  always_ff @(posedge clk) begin
    if (!rst_n) current_instruction <= '0;
    else        current_instruction <= next_pc;
  end

  assign pc_o = current_instruction;
endmodule

module mips_imem (
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [31:0] rdata
);
  logic [7:0] IM [0:255];

  // Contents are preloaded externally; the array only holds its value.
  always_ff @(posedge clk) begin
    IM <= IM;
  end

  assign rdata = {IM[addr], IM[addr + 8'd1], IM[addr + 8'd2], IM[addr + 8'd3]};
endmodule

module mips_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [7:0] dmem [0:255];

  always_ff @(posedge clk) begin
    if (we) begin
      dmem[addr]         <= wdata[31:24];
      dmem[addr + 8'd1]  <= wdata[23:16];
      dmem[addr + 8'd2]  <= wdata[15:8];
      dmem[addr + 8'd3]  <= wdata[7:0];
    end
  end

  assign rdata = {dmem[addr], dmem[addr + 8'd1], dmem[addr + 8'd2], dmem[addr + 8'd3]};
endmodule

module mips_rf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] RF [0:31];

  // $0 is cleared on reset and never written afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) RF[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      RF[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : RF[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : RF[ra2];
endmodule

module mips_single_cycle (
  input logic clk,
  input logic rst_n
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  logic [31:0] instruction;
  logic [31:0] pc_cur;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_sext;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  logic    reg_write;
  logic    mem_write;
  logic    reg_dst_rd;
  logic    alu_src_imm;
  logic    mem_to_reg;
  logic    branch;
  logic    jump;
  alu_op_e alu_op;

  mips_pc pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .next_pc (next_pc),
    .pc_o    (pc_cur)
  );

  mips_imem imem (
    .clk   (clk),
    .addr  (pc_cur[7:0]),
    .rdata (instruction)
  );

  mips_rf rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (reg_write & rst_n),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (wb_addr),
    .wd    (wb_data),
    .rd1   (rs_data),
    .rd2   (rt_data)
  );

  mips_dmem dmem (
    .clk   (clk),
    .we    (mem_write & rst_n),
    .addr  (alu_result[7:0]),
    .wdata (rt_data),
    .rdata (mem_rdata)
  );

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];
  assign imm    = instruction[15:0];
  assign target = instruction[25:0];

  assign imm_sext = {{16{imm[15]}}, imm};

  // Main decoder; anything unrecognised falls through as a no-op.
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    reg_dst_rd  = 1'b0;
    alu_src_imm = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_op      = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        reg_dst_rd = 1'b1;
        unique case (funct)
          FN_ADD: begin reg_write = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin reg_write = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin reg_write = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin reg_write = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin reg_write = 1'b1; alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        mem_write   = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_ADDI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_BEQ:  branch = 1'b1;
      OP_J:    jump   = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = alu_src_imm ? imm_sext : rt_data;

  always_comb begin
    alu_result = 32'd0;
    unique case (alu_op)
      ALU_ADD: alu_result = rs_data + alu_b;
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_AND: alu_result = rs_data & alu_b;
      ALU_OR:  alu_result = rs_data | alu_b;
      ALU_SLT: alu_result = {31'd0, ($signed(rs_data) < $signed(alu_b))};
      default: alu_result = 32'd0;
    endcase
  end

  assign wb_addr = reg_dst_rd ? rd : rt;
  assign wb_data = mem_to_reg ? mem_rdata : alu_result;

  assign pc_plus4 = pc_cur + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], target, 2'b00};
    else if (branch && (rs_data == rt_data))
      next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
  end
endmodule

// File: tb/tb_mips_single_cycle.sv
// Directed bench for mips_single_cycle: reference program, jump loop,
// branch-not-taken, $0 writes, signed ops, logic ops and mid-run reset.

module tb_mips_single_cycle;
  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  mips_single_cycle dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.imem.IM[i] = 8'h00;
  endtask

  task automatic put_instr(input int addr, input logic [31:0] w);
    dut.imem.IM[addr]     = w[31:24];
    dut.imem.IM[addr + 1] = w[23:16];
    dut.imem.IM[addr + 2] = w[15:8];
    dut.imem.IM[addr + 3] = w[7:0];
  endtask

  task automatic put_data(input int addr, input logic [31:0] w);
    dut.dmem.dmem[addr]     = w[31:24];
    dut.dmem.dmem[addr + 1] = w[23:16];
    dut.dmem.dmem[addr + 2] = w[15:8];
    dut.dmem.dmem[addr + 3] = w[7:0];
  endtask

  function automatic logic [31:0] get_data(input int addr);
    return {dut.dmem.dmem[addr], dut.dmem.dmem[addr + 1],
            dut.dmem.dmem[addr + 2], dut.dmem.dmem[addr + 3]};
  endfunction

  task automatic load_reference();
    clear_imem();
    for (int i = 0; i < 256; i++) dut.dmem.dmem[i] = 8'h00;
    put_data(0, 32'h0000_0005);
    put_data(4, 32'h0000_0003);
    put_instr(0,   32'h8C01_0000);
    put_instr(4,   32'h8C02_0004);
    put_instr(8,   32'h0022_1820);
    put_instr(12,  32'h0022_2022);
    put_instr(16,  32'hAD03_0008);
    put_instr(20,  32'hAD04_000C);
    put_instr(24,  32'h8D05_000C);
    put_instr(28,  32'h0045_1020);
    put_instr(32,  32'h1022_0010);
    put_instr(100, 32'h0800_0019);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_reference();
    step(2);
    vectors++;
    if (dut.pc.current_instruction !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_pc: got %h expected 00000000", dut.pc.current_instruction);
    end
    for (int r = 1; r < 32; r++) begin
      vectors++;
      if (dut.rf.RF[r] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_r%0d: got %h expected 00000000", r, dut.rf.RF[r]);
      end
    end
    vectors++;
    if (get_data(0) !== 32'h5) begin
      miscompares++;
      $display("FAIL reset_dmem0: got %h expected 00000005", get_data(0));
    end
    vectors++;
    if (dut.instruction !== 32'h8C01_0000) begin
      miscompares++;
      $display("FAIL reset_fetch: got %h expected 8c010000", dut.instruction);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reference();
    logic [31:0] exp_r [1:5];
    exp_r[1] = 32'd5; exp_r[2] = 32'd5; exp_r[3] = 32'd8;
    exp_r[4] = 32'd2; exp_r[5] = 32'd2;
    step(9);
    for (int r = 1; r <= 5; r++) begin
      vectors++;
      if (dut.rf.RF[r] !== exp_r[r]) begin
        miscompares++;
        $display("FAIL ref_r%0d: got %h expected %h", r, dut.rf.RF[r], exp_r[r]);
      end
    end
    vectors++;
    if (get_data(8) !== 32'd8) begin
      miscompares++;
      $display("FAIL ref_m8: got %h expected 00000008", get_data(8));
    end
    vectors++;
    if (get_data(12) !== 32'd2) begin
      miscompares++;
      $display("FAIL ref_m12: got %h expected 00000002", get_data(12));
    end
    vectors++;
    if (dut.pc.current_instruction !== 32'h64) begin
      miscompares++;
      $display("FAIL ref_pc: got %h expected 00000064", dut.pc.current_instruction);
    end
  endtask

  task automatic test_jump_loop();
    for (int c = 0; c < 4; c++) begin
      step(1);
      vectors++;
      if (dut.pc.current_instruction !== 32'h64) begin
        miscompares++;
        $display("FAIL jloop_pc%0d: got %h expected 00000064", c, dut.pc.current_instruction);
      end
    end
    vectors++;
    if (dut.rf.RF[2] !== 32'd5 || dut.rf.RF[3] !== 32'd8) begin
      miscompares++;
      $display("FAIL jloop_regs: got r2=%h r3=%h expected 00000005/00000008",
               dut.rf.RF[2], dut.rf.RF[3]);
    end
    vectors++;
    if (get_data(8) !== 32'd8 || get_data(12) !== 32'd2 || get_data(0) !== 32'd5) begin
      miscompares++;
      $display("FAIL jloop_mem: got m0=%h m8=%h m12=%h expected 5/8/2",
               get_data(0), get_data(8), get_data(12));
    end
  endtask

  // Program for branch-not-taken, $0 write, signed and logic ops.
  task automatic load_misc();
    clear_imem();
    put_instr(0,    32'h2001_0005);
    put_instr(4,    32'h2002_0003);
    put_instr(32,   32'h1022_0010);
    put_instr(36,   32'h0022_0020);
    put_instr(40,   32'h2006_FFFF);
    put_instr(44,   32'h00C0_382A);
    put_instr(48,   32'h0001_4022);
    put_instr(52,   32'h0022_4824);
    put_instr(56,   32'h0022_5025);
    put_instr(60,   32'h0022_5826);
  endtask

  task automatic test_beq_not_taken();
    rst_n = 1'b0;
    load_misc();
    step(2);
    rst_n = 1'b1;
    step(8);
    vectors++;
    if (dut.pc.current_instruction !== 32'h20 || dut.rf.RF[1] !== 32'd5 || dut.rf.RF[2] !== 32'd3) begin
      miscompares++;
      $display("FAIL beq_setup: got pc=%h r1=%h r2=%h expected 20/5/3",
               dut.pc.current_instruction, dut.rf.RF[1], dut.rf.RF[2]);
    end
    step(1);
    vectors++;
    if (dut.pc.current_instruction !== 32'h24) begin
      miscompares++;
      $display("FAIL beq_nt_pc: got %h expected 00000024", dut.pc.current_instruction);
    end
  endtask

  task automatic test_write_r0();
    step(1);
    vectors++;
    if (dut.rf.RF[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL r0_write: got %h expected 00000000", dut.rf.RF[0]);
    end
    vectors++;
    if (dut.pc.current_instruction !== 32'h28) begin
      miscompares++;
      $display("FAIL r0_pc: got %h expected 00000028", dut.pc.current_instruction);
    end
  endtask

  task automatic test_signed_ops();
    step(1);
    vectors++;
    if (dut.rf.RF[6] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL addi_neg: got %h expected ffffffff", dut.rf.RF[6]);
    end
    step(1);
    vectors++;
    if (dut.rf.RF[7] !== 32'd1) begin
      miscompares++;
      $display("FAIL slt_neg: got %h expected 00000001", dut.rf.RF[7]);
    end
    step(1);
    vectors++;
    if (dut.rf.RF[8] !== 32'hFFFF_FFFB) begin
      miscompares++;
      $display("FAIL sub_neg: got %h expected fffffffb", dut.rf.RF[8]);
    end
  endtask

  task automatic test_logic_and_nop();
    step(1);
    vectors++;
    if (dut.rf.RF[9] !== 32'd1) begin
      miscompares++;
      $display("FAIL and_op: got %h expected 00000001", dut.rf.RF[9]);
    end
    step(1);
    vectors++;
    if (dut.rf.RF[10] !== 32'd7) begin
      miscompares++;
      $display("FAIL or_op: got %h expected 00000007", dut.rf.RF[10]);
    end
    step(1);
    vectors++;
    if (dut.rf.RF[11] !== 32'd0 || dut.pc.current_instruction !== 32'h40) begin
      miscompares++;
      $display("FAIL bad_funct: got r11=%h pc=%h expected 00000000/00000040",
               dut.rf.RF[11], dut.pc.current_instruction);
    end
    // A run of all-zero words decodes as unsupported funct.
    step(4);
    vectors++;
    if (dut.pc.current_instruction !== 32'h50 || get_data(8) !== 32'd8 || get_data(0) !== 32'd5) begin
      miscompares++;
      $display("FAIL nop_run: got pc=%h m0=%h m8=%h expected 50/5/8",
               dut.pc.current_instruction, get_data(0), get_data(8));
    end
  endtask

  task automatic test_reset_mid_run();
    rst_n = 1'b0;
    load_reference();
    step(2);
    rst_n = 1'b1;
    step(4);
    vectors++;
    if (dut.pc.current_instruction !== 32'h10 || dut.rf.RF[3] !== 32'd8) begin
      miscompares++;
      $display("FAIL mid_setup: got pc=%h r3=%h expected 10/8",
               dut.pc.current_instruction, dut.rf.RF[3]);
    end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    vectors++;
    if (dut.pc.current_instruction !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_pc: got %h expected 00000000", dut.pc.current_instruction);
    end
    vectors++;
    if (dut.rf.RF[1] !== 32'd0 || dut.rf.RF[3] !== 32'd0 || dut.rf.RF[4] !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_regs: got r1=%h r3=%h r4=%h expected zeros",
               dut.rf.RF[1], dut.rf.RF[3], dut.rf.RF[4]);
    end
    vectors++;
    if (get_data(8) !== 32'd0 || get_data(0) !== 32'd5 || get_data(4) !== 32'd3) begin
      miscompares++;
      $display("FAIL mid_dmem: got m0=%h m4=%h m8=%h expected 5/3/0",
               get_data(0), get_data(4), get_data(8));
    end
    step(9);
    vectors++;
    if (dut.pc.current_instruction !== 32'h64 || dut.rf.RF[2] !== 32'd5 ||
        get_data(8) !== 32'd8 || get_data(12) !== 32'd2) begin
      miscompares++;
      $display("FAIL mid_rerun: got pc=%h r2=%h m8=%h m12=%h expected 64/5/8/2",
               dut.pc.current_instruction, dut.rf.RF[2], get_data(8), get_data(12));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    test_reset();
    test_reference();
    test_jump_loop();
    test_beq_not_taken();
    test_write_r0();
    test_signed_ops();
    test_logic_and_nop();
    do_reset();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
